// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake, flush, and gating of control bits on bubbles.
// Define EXMEM_SKID_EN to add a second (skid) entry and a registered in_ready.
module exmem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_aluresult,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_rtdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_aluresult,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rtdata
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rt;
  } beat_t;

`ifdef EXMEM_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1} state_t;
`endif

  state_t r_state, w_nstate;
  beat_t  r_main, w_in_beat;
  logic   r_main_vld;
  logic   w_in_xfer, w_out_xfer;
  logic   w_ld_main_in, w_ld_main_skid, w_ld_skid;

  assign w_in_beat  = '{alu: in_aluresult, rd: in_rd, ctrl: in_ctrl, rt: in_rtdata};
  assign out_valid  = r_main_vld;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_main_vld & out_ready;

`ifdef EXMEM_SKID_EN
  beat_t r_skid;
  logic  r_skid_vld;
  // Skid full is exactly the SKID state, so in_ready is a flop with no path from out_ready.
  assign in_ready = ~r_skid_vld;
`else
  assign in_ready = ~r_main_vld | out_ready;
`endif

  always_comb begin
    w_nstate       = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_nstate     = FULL;
          w_ld_main_in = 1'b1;
        end
      end
      FULL: begin
        if (w_in_xfer && w_out_xfer) begin
          w_ld_main_in = 1'b1;
`ifdef EXMEM_SKID_EN
        end else if (w_in_xfer) begin
          w_nstate  = SKID;
          w_ld_skid = 1'b1;
`endif
        end else if (w_out_xfer) begin
          w_nstate = EMPTY;
        end
      end
`ifdef EXMEM_SKID_EN
      SKID: begin
        if (w_out_xfer) begin
          w_nstate       = FULL;
          w_ld_main_skid = 1'b1;
        end
      end
`endif
      default: w_nstate = EMPTY;
    endcase
    // Flush wins over everything, including a same-cycle input accept.
    if (flush) begin
      w_nstate       = EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_main_vld <= 1'b0;
      r_main     <= '0;
    end else begin
      r_state    <= w_nstate;
      r_main_vld <= (w_nstate != EMPTY);
      if (w_ld_main_in)
        r_main <= w_in_beat;
`ifdef EXMEM_SKID_EN
      else if (w_ld_main_skid)
        r_main <= r_skid;
`endif
    end
  end

`ifdef EXMEM_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_vld <= 1'b0;
      r_skid     <= '0;
    end else begin
      r_skid_vld <= (w_nstate == SKID);
      if (w_ld_skid) r_skid <= w_in_beat;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_ld_main_skid | w_ld_skid;
`endif

  assign out_aluresult = r_main.alu;
  assign out_rd        = r_main.rd;
  assign out_ctrl      = r_main.ctrl & {CTRL_W{r_main_vld}};
  assign out_rtdata    = r_main.rt;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Scoreboard bench for exmem_pipe_reg: accepted beats are queued, and every output cycle is checked against the queue head.
module tb_exmem_pipe_reg;
  localparam int DATA_W = 32, RD_W = 5, CTRL_W = 4;

  logic              clk, rst_n;
  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [DATA_W-1:0] in_aluresult, in_rtdata, out_aluresult, out_rtdata;
  logic [RD_W-1:0]   in_rd, out_rd;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;

  exmem_pipe_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluresult(in_aluresult), .in_rd(in_rd), .in_ctrl(in_ctrl), .in_rtdata(in_rtdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_aluresult(out_aluresult), .out_rd(out_rd), .out_ctrl(out_ctrl), .out_rtdata(out_rtdata)
  );

  typedef struct {
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef EXMEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor and model update on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      logic exp_rdy;
      n = q.size();
      chk("out_valid", {63'd0, out_valid}, {63'd0, n != 0});
      exp_rdy = (CAP == 2) ? (n < 2) : ((n == 0) || out_ready);
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      if (!out_valid)
        chk("bubble_ctrl", {60'd0, out_ctrl}, 64'd0);
      else if (n != 0) begin
        chk("out_alu",  {32'd0, out_aluresult}, {32'd0, q[0].alu});
        chk("out_rd",   {59'd0, out_rd},        {59'd0, q[0].rd});
        chk("out_ctrl", {60'd0, out_ctrl},      {60'd0, q[0].ctrl});
        chk("out_rt",   {32'd0, out_rtdata},    {32'd0, q[0].rt});
      end
      if (out_valid && out_ready && n != 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && in_ready && q.size() < CAP)
        q.push_back('{alu: in_aluresult, rd: in_rd, ctrl: in_ctrl, rt: in_rtdata});
      else if (in_valid && in_ready) begin
        total++; bad++;
        $display("FAIL overflow: accepted beat %0h with %0d held", in_aluresult, q.size());
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] alu, input logic [3:0] ctrl,
                     input logic ordy, input logic fl);
    in_valid     = v;
    in_aluresult = alu;
    in_ctrl      = ctrl;
    in_rd        = RD_W'($urandom);
    in_rtdata    = $urandom;
    out_ready    = ordy;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_alu",   {32'd0, out_aluresult}, 64'd0);
    chk("rst_out_rd",    {59'd0, out_rd}, 64'd0);
    chk("rst_out_ctrl",  {60'd0, out_ctrl}, 64'd0);
    chk("rst_out_rt",    {32'd0, out_rtdata}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 0;
    in_aluresult = '0; in_rd = '0; in_ctrl = '0; in_rtdata = '0;
    #1;
    chk_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Streaming with MEM always ready.
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + i, 4'($urandom), 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Back-pressure then release.
    cyc(1'b1, 32'hA1, 4'b1001, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hA3, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Flush while full with an input offered the same cycle.
    cyc(1'b1, 32'hB1, 4'b1111, 1'b0, 1'b0);
    cyc(1'b1, 32'hB2, 4'b1111, 1'b0, 1'b0);
    cyc(1'b1, 32'hB3, 4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Bubble carrying nonzero control between two beats.
    cyc(1'b1, 32'hC1, 4'b1111, 1'b1, 1'b0);
    cyc(1'b0, 32'hC0, 4'b0011, 1'b1, 1'b0);
    cyc(1'b1, 32'hC2, 4'b0101, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

`ifndef EXMEM_SKID_EN
    // Single-entry build: in_ready follows out_ready within the cycle.
    cyc(1'b1, 32'hD1, 4'b0001, 1'b0, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0; #1;
    chk("comb_rdy_low", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1; #1;
    chk("comb_rdy_high", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
`endif

    // Asynchronous reset with a valid beat held.
    cyc(1'b1, 32'hE1, 4'b1111, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 9) < 7), $urandom, 4'($urandom),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
